// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - fetch sequencer between PC and instruction memory bus
module instruction_fetch #(
    parameter int DATA_WIDTH = 16,
    parameter int TIMEOUT    = 8,
    parameter int CNT_WIDTH  = 4
) (
    input  logic                  clock,
    input  logic                  notReset,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] pc_addr,
    output logic                  pc_inc,
    output logic [DATA_WIDTH-1:0] mem_addr,
    output logic                  mem_read,
    input  logic                  mem_ack,
    input  logic [DATA_WIDTH-1:0] mem_data,
    output logic [DATA_WIDTH-1:0] ir,
    output logic                  ir_valid,
    output logic                  busy,
    output logic                  fault
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        DONE  = 2'd2,
        FAULT = 2'd3
    } state_t;

    localparam logic [CNT_WIDTH-1:0] LAST_WAIT = CNT_WIDTH'(TIMEOUT - 1);

    state_t               state;
    state_t               state_next;
    logic [CNT_WIDTH-1:0] wait_cnt;

    always_ff @(posedge clock or negedge notReset) begin
        if (!notReset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = pc_addr[0] ? FAULT : REQ;
                end
            end
            REQ: begin
                // an ack on the last permitted cycle beats the timeout
                if (mem_ack) begin
                    state_next = DONE;
                end else if (wait_cnt == LAST_WAIT) begin
                    state_next = FAULT;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            FAULT: begin
                if (start) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge notReset) begin
        if (!notReset) begin
            mem_addr <= '0;
            ir       <= '0;
            wait_cnt <= '0;
        end else begin
            if (state == IDLE && start) begin
                mem_addr <= pc_addr;
                wait_cnt <= '0;
            end
            if (state == REQ) begin
                if (mem_ack) begin
                    ir <= mem_data;
                end else if (wait_cnt != LAST_WAIT) begin
                    wait_cnt <= wait_cnt + 1'b1;
                end
            end
        end
    end

    assign mem_read = (state == REQ);
    assign busy     = (state == REQ) || (state == DONE);
    assign pc_inc   = (state == DONE);
    assign ir_valid = (state == DONE);
    assign fault    = (state == FAULT);

endmodule

// File: tb/tb_instruction_fetch.sv
// tb/tb_instruction_fetch.sv - randomized self-checking bench for instruction_fetch
module tb_instruction_fetch;

    localparam int DW      = 16;
    localparam int TIMEOUT = 8;
    localparam int CW      = 4;

    logic          clock = 1'b0;
    logic          notReset = 1'b0;
    logic          start = 1'b0;
    logic [DW-1:0] pc_addr = '0;
    logic          pc_inc;
    logic [DW-1:0] mem_addr;
    logic          mem_read;
    logic          mem_ack = 1'b0;
    logic [DW-1:0] mem_data = '0;
    logic [DW-1:0] ir;
    logic          ir_valid;
    logic          busy;
    logic          fault;

    int            n_checks = 0;
    int            n_fail   = 0;
    logic [DW-1:0] exp_ir   = '0;

    instruction_fetch #(.DATA_WIDTH(DW), .TIMEOUT(TIMEOUT), .CNT_WIDTH(CW)) dut (
        .clock    (clock),
        .notReset (notReset),
        .start    (start),
        .pc_addr  (pc_addr),
        .pc_inc   (pc_inc),
        .mem_addr (mem_addr),
        .mem_read (mem_read),
        .mem_ack  (mem_ack),
        .mem_data (mem_data),
        .ir       (ir),
        .ir_valid (ir_valid),
        .busy     (busy),
        .fault    (fault)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_fault"}, fault, 0);
        check({tag, "_rd"}, mem_read, 0);
        check({tag, "_ir"}, ir, exp_ir);
    endtask

    // In FAULT: a start pulse must return to IDLE without launching a bus cycle.
    task automatic clear_fault();
        pc_addr = DW'($urandom) & ~DW'(1);
        start   = 1'b1;
        @(negedge clock);
        start = 1'b0;
        check_idle("clear");
        @(negedge clock);
        check("clear_no_req", mem_read, 0);
    endtask

    // One fetch from IDLE; ack arrives in REQ cycle 'delay' (0-based), never if delay >= TIMEOUT.
    task automatic do_fetch(input logic [DW-1:0] addr, input int delay, input logic [DW-1:0] data);
        int n;
        int exp_n;
        int pcinc_seen;
        pc_addr = addr;
        start   = 1'b1;
        mem_ack = 1'b0;
        @(negedge clock);
        start = 1'b0;
        if (addr[0]) begin
            check("odd_fault", fault, 1);
            check("odd_rd", mem_read, 0);
            check("odd_addr", mem_addr, addr);
            @(negedge clock);
            check("odd_sticky", fault, 1);
            check("odd_rd2", mem_read, 0);
            clear_fault();
            return;
        end
        n = 0;
        pcinc_seen = 0;
        while (mem_read === 1'b1 && n < TIMEOUT + 4) begin
            check("req_addr", mem_addr, addr);
            if (pc_inc) pcinc_seen++;
            mem_ack  = (n == delay);
            mem_data = (n == delay) ? data : DW'($urandom);
            start    = 1'($urandom);
            n++;
            @(negedge clock);
        end
        mem_ack  = 1'($urandom);
        mem_data = DW'($urandom);
        start    = (delay < TIMEOUT) ? 1'($urandom) : 1'b0;
        exp_n = (delay < TIMEOUT) ? delay + 1 : TIMEOUT;
        check("req_cycles", n, exp_n);
        check("req_no_pcinc", pcinc_seen, 0);
        if (delay < TIMEOUT) begin
            exp_ir = data;
            check("done_valid", ir_valid, 1);
            check("done_pcinc", pc_inc, 1);
            check("done_busy", busy, 1);
            check("done_ir", ir, exp_ir);
            check("done_fault", fault, 0);
            @(negedge clock);
            start = 1'b0;
            check("post_valid", ir_valid, 0);
            check("post_pcinc", pc_inc, 0);
            check_idle("post");
        end else begin
            check("to_fault", fault, 1);
            check("to_ir", ir, exp_ir);
            check("to_pcinc", pc_inc, 0);
            repeat (2) begin
                @(negedge clock);
                check("to_sticky", fault, 1);
                check("to_rd", mem_read, 0);
            end
            mem_ack = 1'b0;
            clear_fault();
        end
        mem_ack = 1'b0;
    endtask

    initial begin
        logic [DW-1:0] model_pc;
        logic [DW-1:0] exp_addr[$];
        int            valid_cyc[$];
        int            d;
        logic [DW-1:0] a;

        #12;
        check("rst_ir", ir, 0);
        check("rst_addr", mem_addr, 0);
        check("rst_rd", mem_read, 0);
        check("rst_busy", busy, 0);
        check("rst_fault", fault, 0);
        check("rst_valid", ir_valid, 0);
        check("rst_pcinc", pc_inc, 0);
        @(negedge clock);
        notReset = 1'b1;
        @(negedge clock);

        do_fetch(16'h0010, 2, 16'hBEEF);
        do_fetch(16'h0040, TIMEOUT, 16'h1234);
        do_fetch(16'h0042, TIMEOUT - 1, 16'hCAFE);
        do_fetch(16'h0011, 0, 16'h0000);
        check("odd_kept_ir", ir, exp_ir);

        // IDLE with stray acks and no start must leave everything alone
        repeat (4) begin
            mem_ack  = 1'b1;
            mem_data = DW'($urandom);
            @(negedge clock);
            check_idle("stray");
        end
        mem_ack = 1'b0;

        // back-to-back zero-wait fetches with a PC model
        model_pc = 16'h0000;
        mem_ack  = 1'b1;
        start    = 1'b1;
        for (int c = 0; c < 9; c++) begin
            pc_addr  = model_pc;
            mem_data = mem_addr ^ 16'hA5A5;
            @(negedge clock);
            if (mem_read) exp_addr.push_back(mem_addr);
            if (ir_valid) begin
                valid_cyc.push_back(c);
                check("b2b_ir", ir, (model_pc ^ 16'hA5A5));
                model_pc = model_pc + 16'd2;
            end
        end
        start   = 1'b0;
        mem_ack = 1'b0;
        exp_ir  = 16'h0004 ^ 16'hA5A5;
        check("b2b_count", valid_cyc.size(), 3);
        check("b2b_reqs", exp_addr.size(), 3);
        for (int i = 0; i < 3; i++) begin
            if (i < exp_addr.size()) check("b2b_addr", exp_addr[i], 2 * i);
            if (i < valid_cyc.size()) check("b2b_cycle", valid_cyc[i], 3 * i + 1);
        end
        @(negedge clock);
        @(negedge clock);
        check_idle("b2b_end");

        // asynchronous reset in the middle of REQ
        pc_addr = 16'h0030;
        start   = 1'b1;
        @(negedge clock);
        start = 1'b0;
        check("mid_rd_before", mem_read, 1);
        #2 notReset = 1'b0;
        #1;
        exp_ir = '0;
        check("mid_rd", mem_read, 0);
        check("mid_busy", busy, 0);
        check("mid_ir", ir, 0);
        check("mid_addr", mem_addr, 0);
        @(negedge clock);
        #3 notReset = 1'b1;
        @(negedge clock);
        check_idle("mid_after");
        do_fetch(16'h0020, 0, 16'h5A5A);

        // randomized fetches
        for (int i = 0; i < 25; i++) begin
            a = DW'($urandom);
            if ($urandom_range(0, 4) != 0) a[0] = 1'b0;
            d = $urandom_range(0, TIMEOUT + 1);
            do_fetch(a, d, DW'($urandom));
            repeat ($urandom_range(0, 2)) begin
                @(negedge clock);
                check_idle("rand_gap");
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
- Fetch sequencer between the program counter and the instruction memory bus.
- Samples the PC's byte-address output and runs a request/acknowledge read with a bounded wait.
- Latches the returned word into an instruction register, then pulses the PC increment strobe so the next fetch sees the advanced address.
- Sits in the CPU control path, downstream of the PC and upstream of the decoder.

Parameters:
DATA_WIDTH, 16, width of address, memory data and instruction register
TIMEOUT, 8, max REQ cycles without mem_ack before fault (>=1)
CNT_WIDTH, 4, width of wait counter; must hold TIMEOUT-1

Ports:
clock  input  1  system clock, all state on rising edge
notReset  input  1  asynchronous, active-low reset
start  input  1  fetch request, sampled in IDLE and FAULT only
pc_addr  input  DATA_WIDTH  byte address from PC output (bit 0 expected 0)
pc_inc  output  1  one-cycle strobe to PC inc input
mem_addr  output  DATA_WIDTH  registered fetch address
mem_read  output  1  read request, high throughout REQ
mem_ack  input  1  memory acknowledge; data valid when high
mem_data  input  DATA_WIDTH  read data from memory
ir  output  DATA_WIDTH  instruction register
ir_valid  output  1  one-cycle pulse: ir holds freshly fetched word
busy  output  1  high in REQ and DONE
fault  output  1  high in FAULT (odd address or timeout)

Behaviour:
- Reset (notReset low, asynchronous):
  - State goes to IDLE immediately, regardless of clock.
  - ir=0, mem_addr=0, wait counter=0.
  - mem_read, pc_inc, ir_valid, busy and fault all low.
  - Reset mid-REQ drops mem_read without waiting for mem_ack.
- States: IDLE, REQ, DONE, FAULT. All outputs are decoded from registered state only.
- IDLE:
  - start=1 and pc_addr[0]=0: mem_addr<=pc_addr, counter<=0, go to REQ.
  - start=1 and pc_addr[0]=1: mem_addr<=pc_addr, go to FAULT; no bus cycle is issued.
  - start=0: stay in IDLE.
- REQ (mem_read=1, busy=1):
  - mem_ack=1: ir<=mem_data, go to DONE.
  - mem_ack=0 and counter==TIMEOUT-1: go to FAULT; ir unchanged.
  - Otherwise counter<=counter+1, stay in REQ.
  - REQ therefore lasts at most TIMEOUT cycles.
  - mem_ack on the final permitted cycle wins over timeout.
  - start is ignored in REQ.
- DONE (one cycle; pc_inc=1, ir_valid=1, busy=1, mem_read=0): go to IDLE unconditionally. start is ignored.
- Latency: start edge to ir_valid = 2 + (cycles of REQ before ack) edges. Zero-wait ack gives ir_valid in the 2nd cycle after start is sampled.
- PC hand-off:
  - The PC increments on the edge that ends DONE.
  - pc_addr is valid for the next fetch from the first IDLE cycle after DONE.
  - Back-to-back fetch: start held high yields one fetch every 3 cycles at zero wait.
- FAULT:
  - fault=1 and sticky; mem_read=0, pc_inc=0.
  - mem_addr keeps the faulting address for debug.
  - start=1 clears the fault and goes to IDLE; no fetch is launched on that edge.
- mem_ack outside REQ is ignored; ir never changes outside the REQ->DONE edge.
- Width rules:
  - Counter compares against TIMEOUT-1 at CNT_WIDTH bits.
  - TIMEOUT=1 means fault after a single unacknowledged REQ cycle.
  - No address arithmetic; mem_addr is pc_addr verbatim.

Test Plan:
- Reset, pc_addr=0x0010, start pulse, mem_ack on 3rd REQ cycle with mem_data=0xBEEF -> mem_read high exactly 3 cycles, mem_addr=0x0010, then ir=0xBEEF with ir_valid and pc_inc high for exactly one cycle, busy low afterwards.
- Zero-wait: mem_ack tied high, start held high, pc_addr stepping 0x0000,0x0002,0x0004 via model PC -> ir_valid every 3rd cycle, three fetches with mem_addr 0x0000/0x0002/0x0004.
- Timeout with TIMEOUT=8, mem_ack never asserted -> mem_read high exactly 8 cycles, then fault=1 persisting, ir unchanged, no pc_inc. start pulse -> fault=0, state IDLE, no mem_read on that edge.
- Ack on final cycle: mem_ack first high on the 8th REQ cycle -> normal DONE, fault stays 0.
- Odd address pc_addr=0x0011, start -> fault=1 next cycle, mem_read never asserts, mem_addr=0x0011.
- Reset mid-REQ: notReset low between clock edges during REQ -> mem_read, busy low immediately, ir=0. After release, start with pc_addr=0x0020 performs a clean fetch. Also check that mem_ack or start pulses during DONE and IDLE-without-start leave ir and state unchanged.
